// File: rtl/id_ex_issue_ctrl.sv
// rtl/id_ex_issue_ctrl.sv - ID->EX pipeline register issue/stall/flush controller
// Load-use hazard bubbles, EX backpressure hold and multi-cycle flush sequencing.
// Define IDEX_CTRL_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module id_ex_issue_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int LU_BUBBLES   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_uses_src2,
   output logic                  id_ready,
   input  logic [REG_ADDR_W-1:0] ex_dest,
   input  logic                  ex_mem_read,
   input  logic                  ex_ready,
   input  logic                  flush,
   output logic                  reg_load,
   output logic                  reg_bubble,
   output logic                  ex_valid,
   output logic [1:0]            state
`ifdef IDEX_CTRL_PERF_EN
   ,
   output logic [31:0]           stall_cnt,
   output logic [31:0]           flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      LU    = 2'd2,
      FLUSH = 2'd3
   } stateT;

   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [3:0] LU_RELOAD    = 4'(LU_BUBBLES - 1);

   stateT      curState;
   stateT      nxtState;
   logic [3:0] cnt;
   logic [3:0] cntNxt;
   logic       exValidQ;
   logic       exValidNxt;
   logic       hazard;
   logic       runEval;

   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign hazard = id_valid & exValidQ & ex_mem_read & (ex_dest != '0) &
                   ((ex_dest == id_src1) | (id_uses_src2 & (ex_dest == id_src2)));

   assign ex_valid = exValidQ;
   assign state    = curState;

   always_ff @(posedge clk) begin
      if (rst) begin
         curState <= RUN;
         cnt      <= 4'd0;
         exValidQ <= 1'b0;
      end else begin
         curState <= nxtState;
         cnt      <= cntNxt;
         exValidQ <= exValidNxt;
      end
   end

   always_comb begin
      nxtState   = curState;
      cntNxt     = cnt;
      exValidNxt = exValidQ;
      reg_load   = 1'b1;
      reg_bubble = 1'b1;
      id_ready   = 1'b0;
      runEval    = 1'b0;

      unique case (curState)
         RUN, HOLD: runEval = 1'b1;
         LU: begin
            // last bubble already sits in EX, so this cycle may issue directly
            if (flush || cnt == 4'd0) begin
               runEval = 1'b1;
            end else begin
               cntNxt     = cnt - 4'd1;
               exValidNxt = 1'b0;
            end
         end
         FLUSH: begin
            exValidNxt = 1'b0;
            if (flush) begin
               cntNxt = FLUSH_RELOAD;
            end else if (cnt == 4'd0) begin
               nxtState = RUN;
            end else begin
               cntNxt = cnt - 4'd1;
            end
         end
         default: nxtState = RUN;
      endcase

      if (runEval) begin
         if (flush) begin
            nxtState   = FLUSH;
            cntNxt     = FLUSH_RELOAD;
            exValidNxt = 1'b0;
         end else if (exValidQ && !ex_ready) begin
            reg_load = 1'b0;
            nxtState = HOLD;
         end else if (hazard) begin
            nxtState   = LU;
            cntNxt     = LU_RELOAD;
            exValidNxt = 1'b0;
         end else begin
            nxtState   = RUN;
            reg_bubble = !id_valid;
            id_ready   = id_valid;
            exValidNxt = id_valid;
         end
      end

      if (rst) begin
         id_ready   = 1'b0;
         reg_load   = 1'b1;
         reg_bubble = 1'b1;
      end
   end

`ifdef IDEX_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= 32'd0;
         flush_cnt <= 32'd0;
      end else begin
         if ((curState == HOLD || curState == LU) && id_valid) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (flush) begin
            flush_cnt <= flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_issue_ctrl.sv
// tb/tb_id_ex_issue_ctrl.sv - directed and randomized bench for id_ex_issue_ctrl
module tb_id_ex_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_src1;
   logic [4:0] id_src2;
   logic       id_uses_src2;
   logic       id_ready;
   logic [4:0] ex_dest;
   logic       ex_mem_read;
   logic       ex_ready;
   logic       flush;
   logic       reg_load;
   logic       reg_bubble;
   logic       ex_valid;
   logic [1:0] state;

   int total = 0;
   int bad   = 0;

   id_ex_issue_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_uses_src2(id_uses_src2), .id_ready(id_ready), .ex_dest(ex_dest),
      .ex_mem_read(ex_mem_read), .ex_ready(ex_ready), .flush(flush), .reg_load(reg_load),
      .reg_bubble(reg_bubble), .ex_valid(ex_valid), .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; id_valid = 1'b1; id_src1 = 5'd1; id_src2 = 5'd2; id_uses_src2 = 1'b1;
      ex_dest = 5'd0; ex_mem_read = 1'b0; ex_ready = 1'b1; flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL reset_id_ready cyc=%0d got=%b exp=0", i, id_ready); end
         total++; if (reg_load !== 1'b1) begin bad++; $display("FAIL reset_reg_load cyc=%0d got=%b exp=1", i, reg_load); end
         total++; if (reg_bubble !== 1'b1) begin bad++; $display("FAIL reset_reg_bubble cyc=%0d got=%b exp=1", i, reg_bubble); end
         tick();
      end
      rst = 1'b0; id_valid = 1'b0;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
      total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
   endtask

   task automatic test_load_use();
      id_valid = 1'b1; id_src1 = 5'd5; id_src2 = 5'd7; id_uses_src2 = 1'b1;
      ex_dest = 5'd0; ex_mem_read = 1'b0; ex_ready = 1'b1;
      @(negedge clk);
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL lu_prime_issue got=%b exp=1", id_ready); end
      tick();
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL lu_prime_ex_valid got=%b exp=1", ex_valid); end
      // EX holds lw x5, ID holds add x6,x5,x7
      ex_dest = 5'd5; ex_mem_read = 1'b1;
      @(negedge clk);
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL lu_stall_id_ready got=%b exp=0", id_ready); end
      total++; if ({reg_load, reg_bubble} !== 2'b11) begin bad++; $display("FAIL lu_bubble load/bubble got=%b exp=11", {reg_load, reg_bubble}); end
      tick();
      total++; if (state !== 2'd2) begin bad++; $display("FAIL lu_state got=%0d exp=2", state); end
      total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_ex_valid got=%b exp=0", ex_valid); end
      ex_dest = 5'd0; ex_mem_read = 1'b0;
      @(negedge clk);
      total++; if ({id_ready, reg_bubble} !== 2'b10) begin bad++; $display("FAIL lu_reissue ready/bubble got=%b exp=10", {id_ready, reg_bubble}); end
      tick();
      total++; if ({state, ex_valid} !== 3'b001) begin bad++; $display("FAIL lu_after state/ex_valid got=%b exp=001", {state, ex_valid}); end
      ex_dest = 5'd6; ex_mem_read = 1'b0;
   endtask

   task automatic test_no_hazard();
      // ex_dest == x0 never hazards
      id_valid = 1'b1; ex_ready = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd0;
      id_src1 = 5'd0; id_src2 = 5'd0; id_uses_src2 = 1'b1;
      @(negedge clk);
      total++; if ({id_ready, reg_bubble} !== 2'b10) begin bad++; $display("FAIL nohz_x0 ready/bubble got=%b exp=10", {id_ready, reg_bubble}); end
      tick();
      total++; if ({state, ex_valid} !== 3'b001) begin bad++; $display("FAIL nohz_x0_after got=%b exp=001", {state, ex_valid}); end
      // src2 matches but is not read
      ex_dest = 5'd5; id_src1 = 5'd1; id_src2 = 5'd5; id_uses_src2 = 1'b0;
      @(negedge clk);
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL nohz_imm id_ready got=%b exp=1", id_ready); end
      tick();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL nohz_imm_state got=%0d exp=0", state); end
      // same pair with src2 read does hazard
      id_uses_src2 = 1'b1;
      @(negedge clk);
      total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL hz_src2 id_ready got=%b exp=0", id_ready); end
      tick();
      total++; if (state !== 2'd2) begin bad++; $display("FAIL hz_src2_state got=%0d exp=2", state); end
      ex_dest = 5'd0; ex_mem_read = 1'b0;
      @(negedge clk);
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL hz_src2_reissue got=%b exp=1", id_ready); end
      tick();
   endtask

   task automatic test_hold();
      id_valid = 1'b1; id_src1 = 5'd3; id_src2 = 5'd4; ex_dest = 5'd0; ex_mem_read = 1'b0; ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++; if ({reg_load, id_ready} !== 2'b00) begin bad++; $display("FAIL hold_cyc%0d load/ready got=%b exp=00", i, {reg_load, id_ready}); end
         tick();
         total++; if (state !== 2'd1) begin bad++; $display("FAIL hold_state cyc=%0d got=%0d exp=1", i, state); end
      end
      ex_ready = 1'b1;
      @(negedge clk);
      total++; if ({id_ready, reg_load, reg_bubble} !== 3'b110) begin bad++; $display("FAIL hold_release got=%b exp=110", {id_ready, reg_load, reg_bubble}); end
      tick();
      total++; if ({state, ex_valid} !== 3'b001) begin bad++; $display("FAIL hold_after got=%b exp=001", {state, ex_valid}); end
   endtask

   task automatic test_flush();
      logic [1:0] expState;
      int loads;
      loads = 0;
      id_valid = 1'b1; ex_ready = 1'b1; flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (reg_load === 1'b1 && reg_bubble === 1'b1) loads++;
         total++; if (id_ready !== 1'b0) begin bad++; $display("FAIL flush_id_ready cyc=%0d got=%b exp=0", i, id_ready); end
         tick();
         flush = 1'b0;
         expState = (i < 2) ? 2'd3 : 2'd0;
         total++; if (state !== expState) begin bad++; $display("FAIL flush_state cyc=%0d got=%0d exp=%0d", i, state, expState); end
         total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL flush_ex_valid cyc=%0d got=%b exp=0", i, ex_valid); end
      end
      total++; if (loads != 3) begin bad++; $display("FAIL flush_bubble_loads got=%0d exp=3", loads); end
      @(negedge clk);
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL flush_resume got=%b exp=1", id_ready); end
      tick();
   endtask

   task automatic test_flush_restart();
      id_valid = 1'b1; ex_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      // FLUSH with cnt==0: a new flush restarts the full sequence
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (state !== 2'd3) begin bad++; $display("FAIL restart_state0 got=%0d exp=3", state); end
      tick();
      total++; if (state !== 2'd3) begin bad++; $display("FAIL restart_state1 got=%0d exp=3", state); end
      tick();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL restart_state2 got=%0d exp=0", state); end
      @(negedge clk);
      total++; if (id_ready !== 1'b1) begin bad++; $display("FAIL restart_resume got=%b exp=1", id_ready); end
      tick();
   endtask

   task automatic test_flush_in_hold();
      id_valid = 1'b1; ex_ready = 1'b0; ex_dest = 5'd5; ex_mem_read = 1'b1; id_src1 = 5'd5;
      tick();
      total++; if (state !== 2'd1) begin bad++; $display("FAIL fhold_enter got=%0d exp=1", state); end
      flush = 1'b1;
      @(negedge clk);
      total++; if ({id_ready, reg_load, reg_bubble} !== 3'b011) begin bad++; $display("FAIL fhold_bubble got=%b exp=011", {id_ready, reg_load, reg_bubble}); end
      tick();
      flush = 1'b0; ex_ready = 1'b1; ex_mem_read = 1'b0;
      total++; if ({state, ex_valid} !== 3'b110) begin bad++; $display("FAIL fhold_state got=%b exp=110", {state, ex_valid}); end
      tick(); tick();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL fhold_done got=%0d exp=0", state); end
   endtask

   task automatic test_flush_in_lu();
      id_valid = 1'b1; ex_ready = 1'b1; ex_dest = 5'd0; ex_mem_read = 1'b0; id_src1 = 5'd9;
      tick();
      ex_dest = 5'd9; ex_mem_read = 1'b1;
      tick();
      total++; if (state !== 2'd2) begin bad++; $display("FAIL flu_enter got=%0d exp=2", state); end
      flush = 1'b1;
      @(negedge clk);
      total++; if ({id_ready, reg_load, reg_bubble} !== 3'b011) begin bad++; $display("FAIL flu_bubble got=%b exp=011", {id_ready, reg_load, reg_bubble}); end
      tick();
      flush = 1'b0; ex_mem_read = 1'b0; ex_dest = 5'd0;
      total++; if (state !== 2'd3) begin bad++; $display("FAIL flu_state got=%0d exp=3", state); end
      tick(); tick();
      total++; if (state !== 2'd0) begin bad++; $display("FAIL flu_done got=%0d exp=0", state); end
   endtask

   task automatic test_random();
      logic [4:0] s1, s2, dst, exD, nD;
      logic       u2, mr, exV, exM, nV, nM, hz, expReady, expLoad, consumed;
      int         issued;
      issued = 0;
      s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7));
      u2 = 1'($urandom_range(0, 1)); dst = 5'($urandom_range(0, 7)); mr = 1'($urandom_range(0, 1));
      exV = 1'b0; exD = 5'd0; exM = 1'b0;
      rst = 1'b1; flush = 1'b0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         id_valid = ($urandom_range(0, 9) < 7);
         ex_ready = ($urandom_range(0, 9) < 6);
         flush = ($urandom_range(0, 49) == 0);
         id_src1 = s1; id_src2 = s2; id_uses_src2 = u2;
         ex_dest = exD; ex_mem_read = exM;
         @(negedge clk);
         hz = id_valid && exV && exM && (exD != 5'd0) && (exD == s1 || (u2 && exD == s2));
         expReady = (state != 2'd3) && !flush && id_valid && !hz && !(exV && !ex_ready);
         expLoad = !((state != 2'd3) && !flush && exV && !ex_ready);
         total++; if (id_ready !== expReady) begin bad++; $display("FAIL rnd_id_ready cyc=%0d got=%b exp=%b", c, id_ready, expReady); end
         total++; if (reg_load !== expLoad) begin bad++; $display("FAIL rnd_reg_load cyc=%0d got=%b exp=%b", c, reg_load, expLoad); end
         total++; if (reg_load === 1'b1 && reg_bubble !== !id_ready) begin bad++; $display("FAIL rnd_reg_bubble cyc=%0d got=%b exp=%b", c, reg_bubble, !id_ready); end
         consumed = (id_ready === 1'b1);
         nV = exV; nD = exD; nM = exM;
         if (reg_load === 1'b1) begin
            nV = consumed; nD = consumed ? dst : 5'd0; nM = consumed ? mr : 1'b0;
         end
         tick();
         exV = nV; exD = nD; exM = nM;
         total++; if (ex_valid !== exV) begin bad++; $display("FAIL rnd_ex_valid cyc=%0d got=%b exp=%b", c, ex_valid, exV); end
         if (consumed) begin
            issued++;
            s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7));
            u2 = 1'($urandom_range(0, 1)); dst = 5'($urandom_range(0, 7)); mr = 1'($urandom_range(0, 1));
         end
      end
      flush = 1'b0;
      total++; if (issued < 1500) begin bad++; $display("FAIL rnd_progress issued=%0d exp>=1500", issued); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_hold();
      test_flush();
      test_flush_restart();
      test_flush_in_hold();
      test_flush_in_lu();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
